// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS BCD stopwatch.
// Optional lap snapshot is enabled in the top level by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

   typedef enum logic {
      ST_STOPPED = 1'b0,
      ST_RUNNING = 1'b1
   } state_e;

   localparam int             BCD_W        = 4;
   localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
   localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;

   // Digit index 1 is the seconds-tens place; every other place counts to 9.
   function automatic logic [BCD_W-1:0] digit_max(input int idx);
      return (idx == 1) ? SEC_TENS_MAX : DIGIT_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD place: wraps to 0 after max and flags a carry on that increment.
// Clear has priority over increment.
module bcd_digit_counter
   import stopwatch_pkg::*;
(
   input  logic             clk_in,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [BCD_W-1:0] max,
   output logic [BCD_W-1:0] q,
   output logic             carry
);

   logic [BCD_W-1:0] q_q;
   logic [BCD_W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc) begin
         q_d = (q_q == max) ? '0 : q_q + 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q     = q_q;
   assign carry = inc & (q_q == max);

endmodule

// File: rtl/stopwatch_mmss_bcd.sv
// MM:SS stopwatch counting rising edges of the 1 Hz divider output.
// Define STOPWATCH_LAP_EN to add lap_in and a frozen-display snapshot.
module stopwatch_mmss_bcd
   import stopwatch_pkg::*;
#(
   parameter int MIN_LIMIT = 59,
   parameter bit WRAP      = 1'b1
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             tick_1hz_in,
   input  logic             start_stop_in,
   input  logic             clear_in,
`ifdef STOPWATCH_LAP_EN
   input  logic             lap_in,
`endif
   output logic [BCD_W-1:0] sec_ones,
   output logic [BCD_W-1:0] sec_tens,
   output logic [BCD_W-1:0] min_ones,
   output logic [BCD_W-1:0] min_tens,
   output logic             running,
   output logic             rollover
);

   localparam logic [BCD_W-1:0] LIM_TENS = BCD_W'(MIN_LIMIT / 10);
   localparam logic [BCD_W-1:0] LIM_ONES = BCD_W'(MIN_LIMIT % 10);

   logic                    tick_d_q;
   state_e                  state_q;
   logic                    held_q;
   logic                    rollover_q;
   logic [3:0][BCD_W-1:0]   live_digits;
   logic [3:0][BCD_W-1:0]   shown_digits;
   logic [3:0]              inc;
   logic [3:0]              carry;
   logic                    sec_evt;
   logic                    step;
   logic                    terminal;
   logic                    term_step;
   logic                    digit_clr;

   assign sec_evt   = tick_1hz_in & ~tick_d_q;
   assign step      = sec_evt & (state_q == ST_RUNNING) & ~clear_in;
   assign terminal  = (live_digits[3] == LIM_TENS) && (live_digits[2] == LIM_ONES) &&
                      (live_digits[1] == SEC_TENS_MAX) && (live_digits[0] == DIGIT_MAX);
   assign term_step = step & terminal;
   // A min_tens carry only happens at 99:59 with wrapping; clearing is the wrap.
   assign digit_clr = clear_in | (term_step & WRAP) | carry[3];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         if (gi == 0) begin : g_first
            assign inc[gi] = step & ~(terminal & ~WRAP);
         end else begin : g_chain
            assign inc[gi] = carry[gi-1];
         end
         bcd_digit_counter u_cnt (
            .clk_in (clk_in),
            .rst    (rst),
            .clr    (digit_clr),
            .inc    (inc[gi]),
            .max    (digit_max(gi)),
            .q      (live_digits[gi]),
            .carry  (carry[gi])
         );
      end
   endgenerate

   // held_q marks a non-wrapping count parked at the terminal value;
   // later steps there are ignored rather than re-signalled.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         tick_d_q   <= 1'b0;
         state_q    <= ST_STOPPED;
         held_q     <= 1'b0;
         rollover_q <= 1'b0;
      end else begin
         tick_d_q   <= tick_1hz_in;
         rollover_q <= term_step & (WRAP | ~held_q);
         if (clear_in) begin
            state_q <= ST_STOPPED;
            held_q  <= 1'b0;
         end else begin
            if (start_stop_in) begin
               state_q <= (state_q == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
            end else if (term_step && !WRAP && !held_q) begin
               state_q <= ST_STOPPED;
            end
            if (term_step && !WRAP) begin
               held_q <= 1'b1;
            end
         end
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic                  lap_hold_q;
   logic [3:0][BCD_W-1:0] snap_q;

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         lap_hold_q <= 1'b0;
         snap_q     <= '0;
      end else if (clear_in) begin
         lap_hold_q <= 1'b0;
         snap_q     <= '0;
      end else if (lap_in) begin
         lap_hold_q <= ~lap_hold_q;
         if (!lap_hold_q) begin
            snap_q <= live_digits;
         end
      end
   end

   assign shown_digits = lap_hold_q ? snap_q : live_digits;
`else
   assign shown_digits = live_digits;
`endif

   assign {min_tens, min_ones, sec_tens, sec_ones} = shown_digits;
   assign running  = (state_q == ST_RUNNING);
   assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_mmss_bcd.sv
// Bench for stopwatch_mmss_bcd: a wrapping and a non-wrapping instance share stimulus,
// a seconds-count model feeds a scoreboard. Lap scenario runs when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_mmss_bcd;

   localparam int LIMIT_S = 59 * 60 + 59;

   logic       clk_in = 1'b0;
   logic       rst    = 1'b1;
   logic       tick   = 1'b0;
   logic [1:0] start  = 2'b00;
   logic       clear  = 1'b0;
`ifdef STOPWATCH_LAP_EN
   logic       lap    = 1'b0;
`endif

   wire [15:0] dig_w, dig_nw;
   wire        run_w, run_nw, ro_w, ro_nw;

   typedef struct packed {
      logic [1:0][15:0] dig;
      logic [1:0]       run;
      logic [1:0]       ro;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   ro_cnt_w = 0;
   int   ro_cnt_nw = 0;
   int   cnt[2];
   bit   run_m[2], held_m[2], lhold_m[2];
   int   snap_m[2];

   always #5 clk_in = ~clk_in;

   stopwatch_mmss_bcd #(.MIN_LIMIT(59), .WRAP(1'b1)) dut_w (
      .clk_in(clk_in), .rst(rst), .tick_1hz_in(tick), .start_stop_in(start[0]), .clear_in(clear),
`ifdef STOPWATCH_LAP_EN
      .lap_in(lap),
`endif
      .sec_ones(dig_w[3:0]), .sec_tens(dig_w[7:4]), .min_ones(dig_w[11:8]), .min_tens(dig_w[15:12]),
      .running(run_w), .rollover(ro_w)
   );

   stopwatch_mmss_bcd #(.MIN_LIMIT(59), .WRAP(1'b0)) dut_nw (
      .clk_in(clk_in), .rst(rst), .tick_1hz_in(tick), .start_stop_in(start[1]), .clear_in(clear),
`ifdef STOPWATCH_LAP_EN
      .lap_in(lap),
`endif
      .sec_ones(dig_nw[3:0]), .sec_tens(dig_nw[7:4]), .min_ones(dig_nw[11:8]), .min_tens(dig_nw[15:12]),
      .running(run_nw), .rollover(ro_nw)
   );

   always @(negedge clk_in) begin
      if (ro_w === 1'b1) ro_cnt_w++;
      if (ro_nw === 1'b1) ro_cnt_nw++;
   end

   function automatic logic [15:0] to_bcd(input int n);
      int mm, ss;
      mm = n / 60;
      ss = n % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   // One stimulus cycle: model predicts, expectation is queued, DUT output popped and compared.
   task automatic drive_cycle(input bit do_tick, input logic [1:0] do_start, input bit do_clear,
                              input bit do_lap, input string name);
      exp_t             e, want;
      bit               stop_t;
      logic [1:0][15:0] got_dig;
      logic [1:0]       got_run, got_ro;
      for (int k = 0; k < 2; k++) begin
         e.ro[k] = 1'b0;
         stop_t  = 1'b0;
         if (do_clear) begin
            cnt[k] = 0; run_m[k] = 0; held_m[k] = 0; lhold_m[k] = 0; snap_m[k] = 0;
         end else begin
            if (do_lap) begin
               if (!lhold_m[k]) snap_m[k] = cnt[k];
               lhold_m[k] = !lhold_m[k];
            end
            if (do_tick && run_m[k]) begin
               if (cnt[k] != LIMIT_S) cnt[k]++;
               else if (k == 0) begin cnt[k] = 0; e.ro[k] = 1'b1; end
               else if (!held_m[k]) begin e.ro[k] = 1'b1; held_m[k] = 1; stop_t = 1'b1; end
            end
            if (do_start[k]) run_m[k] = !run_m[k];
            else if (stop_t) run_m[k] = 0;
         end
         e.dig[k] = lhold_m[k] ? to_bcd(snap_m[k]) : to_bcd(cnt[k]);
         e.run[k] = run_m[k];
      end
      sb.push_back(e);
      @(negedge clk_in);
      tick = do_tick; start = do_start; clear = do_clear;
`ifdef STOPWATCH_LAP_EN
      lap = do_lap;
`endif
      @(negedge clk_in);
      tick = 1'b0; start = 2'b00; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap = 1'b0;
`endif
      want    = sb.pop_front();
      got_dig = {dig_nw, dig_w};
      got_run = {run_nw, run_w};
      got_ro  = {ro_nw, ro_w};
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_dig[k] !== want.dig[k]) begin
            errors++;
            $display("FAIL %s dut%0d digits got %h want %h", name, k, got_dig[k], want.dig[k]);
         end
         checks++;
         if (got_run[k] !== want.run[k]) begin
            errors++;
            $display("FAIL %s dut%0d running got %b want %b", name, k, got_run[k], want.run[k]);
         end
         checks++;
         if (got_ro[k] !== want.ro[k]) begin
            errors++;
            $display("FAIL %s dut%0d rollover got %b want %b", name, k, got_ro[k], want.ro[k]);
         end
      end
      @(negedge clk_in);
      checks++;
      if ({ro_nw, ro_w} !== 2'b00) begin
         errors++;
         $display("FAIL %s rollover_one_cycle got %b want 00", name, {ro_nw, ro_w});
      end
   endtask

   task automatic rises(input int n, input string name);
      for (int i = 0; i < n; i++) drive_cycle(1'b1, 2'b00, 1'b0, 1'b0, name);
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         tick = ~tick;
         checks++;
         if ({dig_nw, dig_w, run_nw, run_w, ro_nw, ro_w} !== 36'd0) begin
            errors++;
            $display("FAIL reset outputs got %h_%h %b%b%b%b want all zero",
                     dig_nw, dig_w, run_nw, run_w, ro_nw, ro_w);
         end
      end
      @(negedge clk_in);
      tick = 1'b0;
      rst  = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cnt[k] = 0; run_m[k] = 0; held_m[k] = 0; lhold_m[k] = 0; snap_m[k] = 0;
      end
      $display("reset: digits %h/%h running %b/%b", dig_w, dig_nw, run_w, run_nw);
   endtask

   task automatic test_count();
      int ro0;
      ro0 = ro_cnt_w + ro_cnt_nw;
      drive_cycle(1'b0, 2'b11, 1'b0, 1'b0, "start");
      rises(75, "count75");
      checks++;
      if (dig_w !== 16'h0115 || dig_nw !== 16'h0115 || {run_nw, run_w} !== 2'b11) begin
         errors++;
         $display("FAIL count75 got %h/%h run %b%b want 0115 run 11", dig_w, dig_nw, run_nw, run_w);
      end
      checks++;
      if (ro_cnt_w + ro_cnt_nw !== ro0) begin
         errors++;
         $display("FAIL count75_no_rollover got %0d pulses want 0", ro_cnt_w + ro_cnt_nw - ro0);
      end
      $display("count: 75 rises -> %h", dig_w);
   endtask

   task automatic test_wrap();
      int rw, rn;
      rises(LIMIT_S - 75, "preload");
      checks++;
      if (dig_w !== 16'h5959 || dig_nw !== 16'h5959) begin
         errors++;
         $display("FAIL preload got %h/%h want 5959", dig_w, dig_nw);
      end
      rw = ro_cnt_w; rn = ro_cnt_nw;
      drive_cycle(1'b1, 2'b00, 1'b0, 1'b0, "terminal");
      checks++;
      if (dig_w !== 16'h0000 || run_w !== 1'b1 || ro_cnt_w - rw !== 1) begin
         errors++;
         $display("FAIL wrap got %h run %b pulses %0d want 0000 run 1 pulses 1", dig_w, run_w, ro_cnt_w - rw);
      end
      checks++;
      if (dig_nw !== 16'h5959 || run_nw !== 1'b0 || ro_cnt_nw - rn !== 1) begin
         errors++;
         $display("FAIL hold got %h run %b pulses %0d want 5959 run 0 pulses 1", dig_nw, run_nw, ro_cnt_nw - rn);
      end
      $display("wrap: wrap=1 -> %h, wrap=0 -> %h", dig_w, dig_nw);
   endtask

   task automatic test_hold_restart();
      int rn;
      rn = ro_cnt_nw;
      drive_cycle(1'b0, 2'b10, 1'b0, 1'b0, "restart_nw");
      rises(2, "held");
      checks++;
      if (dig_nw !== 16'h5959 || run_nw !== 1'b1 || ro_cnt_nw !== rn) begin
         errors++;
         $display("FAIL held got %h run %b pulses %0d want 5959 run 1 pulses 0", dig_nw, run_nw, ro_cnt_nw - rn);
      end
      $display("hold: wrap=0 after restart + 2 rises -> %h", dig_nw);
   endtask

   task automatic test_clear_priority();
      drive_cycle(1'b0, 2'b00, 1'b1, 1'b0, "clear");
      drive_cycle(1'b0, 2'b11, 1'b0, 1'b0, "start");
      rises(9, "count9");
      checks++;
      if (dig_w !== 16'h0009 || dig_nw !== 16'h0009) begin
         errors++;
         $display("FAIL count9 got %h/%h want 0009", dig_w, dig_nw);
      end
      drive_cycle(1'b1, 2'b11, 1'b1, 1'b0, "clear_beats_all");
      checks++;
      if (dig_w !== 16'h0000 || dig_nw !== 16'h0000 || {run_nw, run_w} !== 2'b00) begin
         errors++;
         $display("FAIL clear_beats_all got %h/%h run %b%b want 0000 run 00", dig_w, dig_nw, run_nw, run_w);
      end
      $display("clear: tick+start+clear -> %h running %b", dig_w, run_w);
   endtask

   task automatic test_simultaneous();
      drive_cycle(1'b0, 2'b11, 1'b0, 1'b0, "start");
      rises(3, "count3");
      drive_cycle(1'b1, 2'b11, 1'b0, 1'b0, "tick_stop");
      checks++;
      if (dig_w !== 16'h0004 || run_w !== 1'b0) begin
         errors++;
         $display("FAIL tick_stop got %h run %b want 0004 run 0", dig_w, run_w);
      end
      drive_cycle(1'b1, 2'b11, 1'b0, 1'b0, "tick_start");
      checks++;
      if (dig_w !== 16'h0004 || run_w !== 1'b1) begin
         errors++;
         $display("FAIL tick_start got %h run %b want 0004 run 1", dig_w, run_w);
      end
      $display("simultaneous: tick+start -> %h running %b", dig_w, run_w);
   endtask

`ifdef STOPWATCH_LAP_EN
   task automatic test_lap();
      rises(16, "to20");
      drive_cycle(1'b0, 2'b00, 1'b0, 1'b1, "lap_on");
      rises(10, "lap_frozen");
      checks++;
      if (dig_w !== 16'h0020) begin
         errors++;
         $display("FAIL lap_frozen got %h want 0020", dig_w);
      end
      drive_cycle(1'b0, 2'b00, 1'b0, 1'b1, "lap_off");
      checks++;
      if (dig_w !== 16'h0030) begin
         errors++;
         $display("FAIL lap_release got %h want 0030", dig_w);
      end
      $display("lap: released display -> %h", dig_w);
   endtask
`endif

   task automatic test_async_reset();
      @(negedge clk_in);
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({dig_nw, dig_w, run_nw, run_w} !== 34'd0) begin
         errors++;
         $display("FAIL async_reset got %h/%h run %b%b want 0000 run 00", dig_w, dig_nw, run_nw, run_w);
      end
      @(negedge clk_in);
      rst = 1'b1;
      $display("async reset: digits %h running %b", dig_w, run_w);
   endtask

   initial begin
      test_reset();
      test_count();
      test_wrap();
      test_hold_restart();
      test_clear_priority();
      test_simultaneous();
`ifdef STOPWATCH_LAP_EN
      test_lap();
`endif
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
